sd_request_arbiter: RTL and testbench
=====================================

Name: sd_request_arbiter

Overview:
Shares the single SD card controller command interface between two requesters, e.g. port 0 = CPU bus bridge and port 1 = boot/asset loader.
- Round-robin arbitration.
- Latches the winner's address, operation and write byte, then drives the controller's control register.
- Waits for the controller's completion pulse and returns status/read data with a one-cycle ack.
- Enforces an idle (NOP) hold-off so the controller never re-samples a stale operation.

Parameters:
ADDR_W, 32, SD address width passed to controller
HOLDOFF_CYCLES, 4, cycles of forced NOP after each completion (min 1)
TIMEOUT_CYCLES, 1000000, BUSY watchdog limit (used only with SD_ARB_TIMEOUT_EN)

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_rst  in  1  synchronous, active-high reset
i_req0  in  1  port 0 request; level, held until o_ack0
i_we0  in  1  port 0 op: 1=write, 0=read; stable while i_req0
i_addr0  in  ADDR_W  port 0 address; stable while i_req0
i_wdata0  in  8  port 0 write byte
o_ack0  out  1  one-cycle completion pulse to port 0
o_rdata0  out  8  port 0 read byte, valid from o_ack0, held until next o_ack0
o_status0  out  8  port 0 controller status, same timing as o_rdata0
o_err0  out  1  port 0 timeout flag, same timing as o_rdata0
i_req1, i_we1, i_addr1, i_wdata1, o_ack1, o_rdata1, o_status1, o_err1: same as port 0, for port 1
o_sd_ctrl  out  8  to controller control register: 0=NOP, 1=read, 2=write
o_sd_addr  out  ADDR_W  latched address to controller
o_sd_wdata  out  8  latched write byte to controller
i_sd_rdata  in  8  controller read data
i_sd_status  in  8  controller status register
i_sd_done  in  1  controller completion, one-cycle pulse in i_clk domain (synchronised upstream)
o_busy  out  1  high in every state except IDLE
o_grant  out  1  index of current/last granted port

Behaviour:
- Reset values: o_sd_ctrl=0, o_sd_addr=0, o_sd_wdata=0, all o_ack/o_err=0, o_rdata/o_status=0, o_busy=0, o_grant=0, state=IDLE. Round-robin pointer favours port 0 next.
- Reset mid-operation aborts with no ack. o_sd_ctrl is 0 after the reset edge.
- States: IDLE, BUSY, RESP, HOLDOFF. All outputs registered.
- IDLE:
  - One port requesting: grant it.
  - Both requesting: grant the port not granted last. First grant after reset is port 0.
  - On the grant edge: latch addr, wdata and op; o_sd_ctrl <= we?2:1; o_grant <= idx; go BUSY.
  - Latency: request seen at edge t gives o_sd_ctrl valid after edge t.
- BUSY:
  - Hold o_sd_ctrl, o_sd_addr and o_sd_wdata constant.
  - On i_sd_done: capture i_sd_rdata and i_sd_status into the granted port's output registers; o_sd_ctrl <= 0; go RESP.
  - i_sd_done in any state other than BUSY is ignored.
- RESP: assert o_ackN for exactly one cycle (the cycle after done is sampled); load hold-off counter with HOLDOFF_CYCLES; go HOLDOFF.
- HOLDOFF:
  - o_sd_ctrl=0; decrement counter; at 0 go IDLE.
  - Requests are not sampled here.
  - Minimum spacing from ack to the next o_sd_ctrl!=0 is HOLDOFF_CYCLES+1 cycles.
- Requester handshake:
  - A requester may deassert i_req only after its ack.
  - A requester that keeps i_req high after its ack is a new request.
  - Round-robin guarantees the other port is served in between if it is requesting.
- Deasserting i_req during BUSY does not abort; the ack is still issued.
- Output registers of the non-granted port never change.

Optional Feature:
SD_ARB_TIMEOUT_EN
- Defined:
  - A BUSY cycle counter starts at 0 on entry to BUSY.
  - If it reaches TIMEOUT_CYCLES-1 without i_sd_done: o_sd_ctrl <= 0, status <= 8'hFF, rdata <= 8'h00, o_errN <= 1, go RESP.
  - On normal completion o_errN <= 0.
  - i_sd_done coincident with the timeout cycle counts as normal completion.
- Undefined: no counter logic; BUSY waits indefinitely; o_err0/o_err1 tied 0.

Test Plan:
- Single read: i_req0=1, i_we0=0, i_addr0=32'h200; done after 10 cycles with rdata=8'hA5, status=8'h01 -> o_sd_ctrl=1 and o_sd_addr=32'h200 one cycle after request; o_ack0 pulse one cycle after done; o_rdata0=8'hA5, o_status0=8'h01; o_sd_ctrl=0 during RESP/HOLDOFF.
- Contention: i_req0 and i_req1 both asserted from reset, each held until its ack -> grants ordered 0,1,0,1. o_sd_ctrl=0 for ≥5 cycles between ack and next op (HOLDOFF_CYCLES=4).
- Write: i_req1=1, i_we1=1, i_wdata1=8'h3C -> o_sd_ctrl=2, o_sd_wdata=8'h3C held through BUSY; o_ack1 only; port 0 outputs unchanged.
- Spurious/early: pulse i_sd_done in IDLE and HOLDOFF -> no ack, no state change. Drop i_req0 mid-BUSY -> o_ack0 still issued on done.
- Reset mid-BUSY: assert i_rst two cycles after grant -> o_sd_ctrl=0, o_busy=0 next cycle, no ack. Next simultaneous request grants port 0.
- Timeout (SD_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=50): no done -> o_ack0 with o_err0=1, o_status0=8'hFF exactly after 50 BUSY cycles. Without macro, o_busy remains high after 100 cycles.

Source files
------------

// File: rtl/sd_request_arbiter.sv
// Two-port round-robin arbiter in front of a single SD controller command register.
// Optional BUSY watchdog is compiled in with `define SD_ARB_TIMEOUT_EN.
module sd_request_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned HOLDOFF_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_req0,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [7:0]        i_wdata0,
    output logic              o_ack0,
    output logic [7:0]        o_rdata0,
    output logic [7:0]        o_status0,
    output logic              o_err0,

    input  logic              i_req1,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [7:0]        i_wdata1,
    output logic              o_ack1,
    output logic [7:0]        o_rdata1,
    output logic [7:0]        o_status1,
    output logic              o_err1,

    output logic [7:0]        o_sd_ctrl,
    output logic [ADDR_W-1:0] o_sd_addr,
    output logic [7:0]        o_sd_wdata,
    input  logic [7:0]        i_sd_rdata,
    input  logic [7:0]        i_sd_status,
    input  logic              i_sd_done,

    output logic              o_busy,
    output logic              o_grant
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP,
        HOLDOFF
    } state_t;

    localparam int unsigned HO_W      = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [7:0] CTRL_NOP   = 8'd0;
    localparam logic [7:0] CTRL_READ  = 8'd1;
    localparam logic [7:0] CTRL_WRITE = 8'd2;

    if (HOLDOFF_CYCLES < 1) begin : g_bad_holdoff
        $error("HOLDOFF_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t            state_q, state_d;
    logic              rr_next_q, rr_next_d;
    logic              grant_q, grant_d;
    logic              busy_q, busy_d;
    logic [7:0]        sd_ctrl_q, sd_ctrl_d;
    logic [ADDR_W-1:0] sd_addr_q, sd_addr_d;
    logic [7:0]        sd_wdata_q, sd_wdata_d;
    logic [HO_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic [7:0]        rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [7:0]        status0_q, status0_d, status1_q, status1_d;

    logic              pick;
    logic              pick_we;
    logic              cap_en;
    logic [7:0]        cap_rdata;
    logic [7:0]        cap_status;

`ifdef SD_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0]   busy_cnt_q, busy_cnt_d;
    logic              err0_q, err0_d, err1_q, err1_d;
    logic              cap_err;
`endif

    always_comb begin
        state_d    = state_q;
        rr_next_d  = rr_next_q;
        grant_d    = grant_q;
        sd_ctrl_d  = sd_ctrl_q;
        sd_addr_d  = sd_addr_q;
        sd_wdata_d = sd_wdata_q;
        hold_cnt_d = hold_cnt_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        status0_d  = status0_q;
        status1_d  = status1_q;
        pick       = 1'b0;
        pick_we    = 1'b0;
        cap_en     = 1'b0;
        cap_rdata  = '0;
        cap_status = '0;
`ifdef SD_ARB_TIMEOUT_EN
        busy_cnt_d = busy_cnt_q;
        err0_d     = err0_q;
        err1_d     = err1_q;
        cap_err    = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (i_req0 || i_req1) begin
                    // With both requesting the pointer decides; otherwise the lone requester wins.
                    pick       = (i_req0 && i_req1) ? rr_next_q : i_req1;
                    pick_we    = pick ? i_we1 : i_we0;
                    grant_d    = pick;
                    rr_next_d  = ~pick;
                    sd_addr_d  = pick ? i_addr1 : i_addr0;
                    sd_wdata_d = pick ? i_wdata1 : i_wdata0;
                    sd_ctrl_d  = pick_we ? CTRL_WRITE : CTRL_READ;
                    state_d    = BUSY;
`ifdef SD_ARB_TIMEOUT_EN
                    busy_cnt_d = '0;
`endif
                end
            end
            BUSY: begin
                if (i_sd_done) begin
                    cap_en     = 1'b1;
                    cap_rdata  = i_sd_rdata;
                    cap_status = i_sd_status;
                end
`ifdef SD_ARB_TIMEOUT_EN
                else if (busy_cnt_q == TO_LAST) begin
                    cap_en     = 1'b1;
                    cap_status = 8'hFF;
                    cap_err    = 1'b1;
                end else begin
                    busy_cnt_d = busy_cnt_q + 1'b1;
                end
`endif
                if (cap_en) begin
                    // Ack is registered on the done edge so it is high exactly while in RESP.
                    sd_ctrl_d = CTRL_NOP;
                    state_d   = RESP;
                    ack0_d    = ~grant_q;
                    ack1_d    = grant_q;
                end
            end
            RESP: begin
                hold_cnt_d = HO_W'(HOLDOFF_CYCLES);
                state_d    = HOLDOFF;
            end
            HOLDOFF: begin
                hold_cnt_d = hold_cnt_q - 1'b1;
                if (hold_cnt_q == HO_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cap_en) begin
            if (grant_q) begin
                rdata1_d  = cap_rdata;
                status1_d = cap_status;
`ifdef SD_ARB_TIMEOUT_EN
                err1_d    = cap_err;
`endif
            end else begin
                rdata0_d  = cap_rdata;
                status0_d = cap_status;
`ifdef SD_ARB_TIMEOUT_EN
                err0_d    = cap_err;
`endif
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            rr_next_q  <= 1'b0;
            grant_q    <= 1'b0;
            busy_q     <= 1'b0;
            sd_ctrl_q  <= CTRL_NOP;
            sd_addr_q  <= '0;
            sd_wdata_q <= '0;
            hold_cnt_q <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            status0_q  <= '0;
            status1_q  <= '0;
`ifdef SD_ARB_TIMEOUT_EN
            busy_cnt_q <= '0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_next_q  <= rr_next_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            sd_ctrl_q  <= sd_ctrl_d;
            sd_addr_q  <= sd_addr_d;
            sd_wdata_q <= sd_wdata_d;
            hold_cnt_q <= hold_cnt_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            status0_q  <= status0_d;
            status1_q  <= status1_d;
`ifdef SD_ARB_TIMEOUT_EN
            busy_cnt_q <= busy_cnt_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
`endif
        end
    end

    assign o_sd_ctrl  = sd_ctrl_q;
    assign o_sd_addr  = sd_addr_q;
    assign o_sd_wdata = sd_wdata_q;
    assign o_busy     = busy_q;
    assign o_grant    = grant_q;
    assign o_ack0     = ack0_q;
    assign o_ack1     = ack1_q;
    assign o_rdata0   = rdata0_q;
    assign o_rdata1   = rdata1_q;
    assign o_status0  = status0_q;
    assign o_status1  = status1_q;
`ifdef SD_ARB_TIMEOUT_EN
    assign o_err0     = err0_q;
    assign o_err1     = err1_q;
`else
    assign o_err0     = 1'b0;
    assign o_err1     = 1'b0;
`endif

endmodule

// File: tb/tb_sd_request_arbiter.sv
// Directed self-checking bench for sd_request_arbiter (HOLDOFF_CYCLES=4, TIMEOUT_CYCLES=50).
module tb_sd_request_arbiter;

    localparam int unsigned HOLD = 4;

    logic        clk;
    logic        i_rst;
    logic        i_req0, i_we0, i_req1, i_we1;
    logic [31:0] i_addr0, i_addr1;
    logic [7:0]  i_wdata0, i_wdata1;
    logic        o_ack0, o_ack1, o_err0, o_err1;
    logic [7:0]  o_rdata0, o_status0, o_rdata1, o_status1;
    logic [7:0]  o_sd_ctrl, o_sd_wdata, i_sd_rdata, i_sd_status;
    logic [31:0] o_sd_addr;
    logic        i_sd_done, o_busy, o_grant;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned ack0_seen = 0;
    int unsigned ack1_seen = 0;

    sd_request_arbiter #(
        .ADDR_W(32),
        .HOLDOFF_CYCLES(HOLD),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_req0(i_req0), .i_we0(i_we0), .i_addr0(i_addr0), .i_wdata0(i_wdata0),
        .o_ack0(o_ack0), .o_rdata0(o_rdata0), .o_status0(o_status0), .o_err0(o_err0),
        .i_req1(i_req1), .i_we1(i_we1), .i_addr1(i_addr1), .i_wdata1(i_wdata1),
        .o_ack1(o_ack1), .o_rdata1(o_rdata1), .o_status1(o_status1), .o_err1(o_err1),
        .o_sd_ctrl(o_sd_ctrl), .o_sd_addr(o_sd_addr), .o_sd_wdata(o_sd_wdata),
        .i_sd_rdata(i_sd_rdata), .i_sd_status(i_sd_status), .i_sd_done(i_sd_done),
        .o_busy(o_busy), .o_grant(o_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_ack0 === 1'b1) ack0_seen++;
        if (o_ack1 === 1'b1) ack1_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            if (o_busy === 1'b0) done = 1'b1;
            else tick();
        end
        total++;
        if (!done) begin bad++; $display("FAIL %s_idle: o_busy=%b want 0 within 30 cycles", name, o_busy); end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_req0 = 1'b0; i_req1 = 1'b0; i_we0 = 1'b0; i_we1 = 1'b0;
        i_addr0 = '0; i_addr1 = '0; i_wdata0 = '0; i_wdata1 = '0;
        i_sd_rdata = '0; i_sd_status = '0; i_sd_done = 1'b0;
        tick(); tick();
        total++; if (o_sd_ctrl !== 8'd0) begin bad++; $display("FAIL rst_ctrl: got %0d want 0", o_sd_ctrl); end
        total++; if (o_sd_addr !== 32'd0) begin bad++; $display("FAIL rst_addr: got %h want 0", o_sd_addr); end
        total++; if (o_sd_wdata !== 8'd0) begin bad++; $display("FAIL rst_wdata: got %h want 0", o_sd_wdata); end
        total++; if ({o_ack0, o_ack1, o_err0, o_err1} !== 4'b0000) begin bad++; $display("FAIL rst_ack_err: got %b want 0000", {o_ack0, o_ack1, o_err0, o_err1}); end
        total++; if ({o_rdata0, o_status0, o_rdata1, o_status1} !== 32'd0) begin bad++; $display("FAIL rst_data: got %h want 0", {o_rdata0, o_status0, o_rdata1, o_status1}); end
        total++; if ({o_busy, o_grant} !== 2'b00) begin bad++; $display("FAIL rst_busy_grant: got %b want 00", {o_busy, o_grant}); end
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        i_req0 = 1'b1; i_we0 = 1'b0; i_addr0 = 32'h200;
        tick();
        total++; if (o_sd_ctrl !== 8'd1) begin bad++; $display("FAIL read_ctrl: got %0d want 1", o_sd_ctrl); end
        total++; if (o_sd_addr !== 32'h200) begin bad++; $display("FAIL read_addr: got %h want 200", o_sd_addr); end
        total++; if ({o_busy, o_grant} !== 2'b10) begin bad++; $display("FAIL read_busy_grant: got %b want 10", {o_busy, o_grant}); end
        for (int c = 0; c < 9; c++) tick();
        total++; if (o_ack0 !== 1'b0) begin bad++; $display("FAIL read_early_ack: got %b want 0", o_ack0); end
        i_sd_done = 1'b1; i_sd_rdata = 8'hA5; i_sd_status = 8'h01;
        tick();
        i_sd_done = 1'b0; i_req0 = 1'b0; i_sd_rdata = 8'h00; i_sd_status = 8'h00;
        total++; if ({o_ack0, o_ack1} !== 2'b10) begin bad++; $display("FAIL read_ack: got %b want 10", {o_ack0, o_ack1}); end
        total++; if (o_rdata0 !== 8'hA5) begin bad++; $display("FAIL read_rdata: got %h want a5", o_rdata0); end
        total++; if (o_status0 !== 8'h01) begin bad++; $display("FAIL read_status: got %h want 01", o_status0); end
        total++; if (o_sd_ctrl !== 8'd0) begin bad++; $display("FAIL read_resp_ctrl: got %0d want 0", o_sd_ctrl); end
        for (int c = 0; c < HOLD; c++) begin
            tick();
            total++; if ({o_busy, o_ack0, o_sd_ctrl} !== {1'b1, 1'b0, 8'd0}) begin bad++; $display("FAIL read_holdoff%0d: busy/ack/ctrl got %b/%b/%0d want 1/0/0", c, o_busy, o_ack0, o_sd_ctrl); end
        end
        tick();
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL read_back_idle: got %b want 0", o_busy); end
    endtask

    task automatic test_write();
        i_req1 = 1'b1; i_we1 = 1'b1; i_wdata1 = 8'h3C; i_addr1 = 32'h44;
        tick();
        total++; if ({o_sd_ctrl, o_sd_wdata} !== {8'd2, 8'h3C}) begin bad++; $display("FAIL write_ctrl: ctrl/wdata got %0d/%h want 2/3c", o_sd_ctrl, o_sd_wdata); end
        total++; if (o_grant !== 1'b1) begin bad++; $display("FAIL write_grant: got %b want 1", o_grant); end
        i_wdata1 = 8'h99;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++; if ({o_sd_ctrl, o_sd_wdata, o_sd_addr} !== {8'd2, 8'h3C, 32'h44}) begin bad++; $display("FAIL write_hold%0d: ctrl/wdata/addr got %0d/%h/%h want 2/3c/44", c, o_sd_ctrl, o_sd_wdata, o_sd_addr); end
        end
        i_sd_done = 1'b1; i_sd_rdata = 8'h77; i_sd_status = 8'h02;
        tick();
        i_sd_done = 1'b0; i_req1 = 1'b0;
        total++; if ({o_ack0, o_ack1} !== 2'b01) begin bad++; $display("FAIL write_ack: got %b want 01", {o_ack0, o_ack1}); end
        total++; if ({o_rdata1, o_status1} !== 16'h7702) begin bad++; $display("FAIL write_port1: got %h want 7702", {o_rdata1, o_status1}); end
        total++; if ({o_rdata0, o_status0} !== 16'hA501) begin bad++; $display("FAIL write_port0_kept: got %h want a501", {o_rdata0, o_status0}); end
        wait_idle("write");
    endtask

    task automatic test_spurious();
        int unsigned a0, a1;
        a0 = ack0_seen; a1 = ack1_seen;
        i_sd_done = 1'b1; i_sd_rdata = 8'hEE; i_sd_status = 8'hEE;
        tick();
        i_sd_done = 1'b0;
        total++; if ({o_busy, o_sd_ctrl} !== {1'b0, 8'd0}) begin bad++; $display("FAIL spur_idle: busy/ctrl got %b/%0d want 0/0", o_busy, o_sd_ctrl); end
        total++; if ({o_rdata0, o_rdata1} !== 16'hA577) begin bad++; $display("FAIL spur_idle_data: got %h want a577", {o_rdata0, o_rdata1}); end
        i_req0 = 1'b1; i_we0 = 1'b0; i_addr0 = 32'h300;
        tick(); tick();
        i_req0 = 1'b0;
        tick(); tick();
        i_sd_done = 1'b1; i_sd_rdata = 8'h5A; i_sd_status = 8'h03;
        tick();
        i_sd_done = 1'b0;
        total++; if ({o_ack0, o_rdata0, o_status0} !== {1'b1, 8'h5A, 8'h03}) begin bad++; $display("FAIL drop_req_ack: ack/rdata/status got %b/%h/%h want 1/5a/03", o_ack0, o_rdata0, o_status0); end
        tick();
        i_sd_done = 1'b1; i_sd_rdata = 8'hEE; i_sd_status = 8'hEE;
        tick();
        i_sd_done = 1'b0;
        tick(); tick();
        total++; if ({o_busy, o_sd_ctrl} !== {1'b1, 8'd0}) begin bad++; $display("FAIL spur_holdoff: busy/ctrl got %b/%0d want 1/0", o_busy, o_sd_ctrl); end
        tick();
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL spur_holdoff_len: busy got %b want 0", o_busy); end
        total++; if ((ack0_seen - a0) != 1 || (ack1_seen - a1) != 0) begin bad++; $display("FAIL spur_ack_count: ack0/ack1 got %0d/%0d want 1/0", ack0_seen - a0, ack1_seen - a1); end
        total++; if (o_rdata0 !== 8'h5A) begin bad++; $display("FAIL spur_data: got %h want 5a", o_rdata0); end
    endtask

    task automatic test_contention();
        int unsigned gap;
        bit found;
        logic expg;
        i_rst = 1'b1; i_req0 = 1'b1; i_req1 = 1'b1; i_we0 = 1'b0; i_we1 = 1'b0;
        i_addr0 = 32'h10; i_addr1 = 32'h20;
        tick();
        i_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            gap = 0; found = 1'b0;
            for (int c = 0; c < 20 && !found; c++) begin
                tick();
                if (o_sd_ctrl !== 8'd0) found = 1'b1;
                else gap++;
            end
            expg = (k % 2) == 1;
            total++; if (!found) begin bad++; $display("FAIL cont_wait%0d: no op within 20 cycles, ctrl=%0d want nonzero", k, o_sd_ctrl); end
            total++; if (o_grant !== expg) begin bad++; $display("FAIL cont_grant%0d: got %b want %b", k, o_grant, expg); end
            total++; if (o_sd_addr !== (expg ? 32'h20 : 32'h10)) begin bad++; $display("FAIL cont_addr%0d: got %h want %h", k, o_sd_addr, expg ? 32'h20 : 32'h10); end
            if (k > 0) begin
                total++; if (gap < HOLD + 1) begin bad++; $display("FAIL cont_gap%0d: got %0d idle cycles want >= %0d", k, gap, HOLD + 1); end
            end
            tick(); tick();
            i_sd_done = 1'b1; i_sd_rdata = 8'h40 + 8'(k); i_sd_status = 8'h00;
            tick();
            i_sd_done = 1'b0;
            if (k == 3) begin i_req0 = 1'b0; i_req1 = 1'b0; end
            total++; if ({o_ack0, o_ack1} !== (expg ? 2'b01 : 2'b10)) begin bad++; $display("FAIL cont_ack%0d: got %b want %b", k, {o_ack0, o_ack1}, expg ? 2'b01 : 2'b10); end
            total++; if ((expg ? o_rdata1 : o_rdata0) !== 8'h40 + 8'(k)) begin bad++; $display("FAIL cont_rdata%0d: got %h want %h", k, expg ? o_rdata1 : o_rdata0, 8'h40 + 8'(k)); end
        end
        wait_idle("contention");
    endtask

    task automatic test_reset_mid_busy();
        int unsigned a0;
        a0 = ack0_seen;
        i_req0 = 1'b1; i_we0 = 1'b1; i_wdata0 = 8'h11; i_addr0 = 32'h500;
        tick(); tick();
        i_rst = 1'b1;
        tick();
        total++; if ({o_busy, o_sd_ctrl, o_ack0} !== {1'b0, 8'd0, 1'b0}) begin bad++; $display("FAIL rstmid_state: busy/ctrl/ack got %b/%0d/%b want 0/0/0", o_busy, o_sd_ctrl, o_ack0); end
        i_rst = 1'b0; i_req1 = 1'b1; i_we0 = 1'b0;
        tick();
        total++; if ({o_grant, o_sd_ctrl} !== {1'b0, 8'd1}) begin bad++; $display("FAIL rstmid_regrant: grant/ctrl got %b/%0d want 0/1", o_grant, o_sd_ctrl); end
        total++; if (ack0_seen != a0) begin bad++; $display("FAIL rstmid_noack: got %0d acks want 0", ack0_seen - a0); end
        tick();
        i_sd_done = 1'b1; i_sd_rdata = 8'h21; i_sd_status = 8'h00;
        tick();
        i_sd_done = 1'b0; i_req0 = 1'b0; i_req1 = 1'b0;
        total++; if (o_ack0 !== 1'b1) begin bad++; $display("FAIL rstmid_ack: got %b want 1", o_ack0); end
        wait_idle("rstmid");
    endtask

    task automatic test_timeout();
        i_req0 = 1'b1; i_we0 = 1'b0; i_addr0 = 32'h600;
        tick();
`ifdef SD_ARB_TIMEOUT_EN
        for (int c = 0; c < 49; c++) tick();
        total++; if (o_ack0 !== 1'b0) begin bad++; $display("FAIL to_early: ack got %b want 0 after 49 busy cycles", o_ack0); end
        tick();
        i_req0 = 1'b0;
        total++; if ({o_ack0, o_err0, o_status0, o_rdata0} !== {1'b1, 1'b1, 8'hFF, 8'h00}) begin bad++; $display("FAIL to_resp: ack/err/status/rdata got %b/%b/%h/%h want 1/1/ff/00", o_ack0, o_err0, o_status0, o_rdata0); end
        total++; if (o_err1 !== 1'b0) begin bad++; $display("FAIL to_err1: got %b want 0", o_err1); end
        wait_idle("timeout");
        i_req0 = 1'b1;
        tick(); tick();
        i_sd_done = 1'b1; i_sd_rdata = 8'h31; i_sd_status = 8'h04;
        tick();
        i_sd_done = 1'b0; i_req0 = 1'b0;
        total++; if ({o_ack0, o_err0, o_rdata0} !== {1'b1, 1'b0, 8'h31}) begin bad++; $display("FAIL to_clear: ack/err/rdata got %b/%b/%h want 1/0/31", o_ack0, o_err0, o_rdata0); end
        wait_idle("timeout_clear");
`else
        for (int c = 0; c < 100; c++) tick();
        total++; if ({o_busy, o_ack0, o_err0, o_sd_ctrl} !== {1'b1, 1'b0, 1'b0, 8'd1}) begin bad++; $display("FAIL no_to_wait: busy/ack/err/ctrl got %b/%b/%b/%0d want 1/0/0/1", o_busy, o_ack0, o_err0, o_sd_ctrl); end
        i_req0 = 1'b0; i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_spurious();
        test_contention();
        test_reset_mid_busy();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
